// File: rtl/video_timing_gen.sv
// Raster counters, pixel request strobes, and a response-aligned video stream to the encoder. Option: VIDEO_TIMING_BLANK_ZERO_EN.
// Latency: req_* are one register after the raster position; vid_* follow a request by RESP_LATENCY+1 cycles.
// Backpressure: none; the pixel source must answer every request RESP_LATENCY cycles later.
module video_timing_gen #(
  parameter int H_ACTIVE     = 1280,
  parameter int H_FP         = 110,
  parameter int H_SYNC       = 40,
  parameter int H_BP         = 220,
  parameter int V_ACTIVE     = 720,
  parameter int V_FP         = 5,
  parameter int V_SYNC       = 5,
  parameter int V_BP         = 20,
  parameter bit H_POL        = 1'b1,
  parameter bit V_POL        = 1'b1,
  parameter int RESP_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       req_en,
  output logic       req_sof,
  output logic       req_sol,
  input  logic [7:0] resp_red,
  input  logic [7:0] resp_green,
  input  logic [7:0] resp_blue,
  output logic       vid_de,
  output logic       vid_hsync,
  output logic       vid_vsync,
  output logic [7:0] vid_red,
  output logic [7:0] vid_green,
  output logic [7:0] vid_blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 13-bit bounds so a total of exactly 4096 still compares correctly.
  localparam logic [12:0] H_ACT_B  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG_B = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END_B = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] H_LAST_B = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_ACT_B  = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG_B = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END_B = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] V_LAST_B = 13'(V_TOTAL - 1);

  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic [12:0] hpos;
  logic [12:0] vpos;
  logic        h_last;
  logic        v_last;
  logic        active;
  logic        hs_raw;
  logic        vs_raw;

  always_comb begin
    hpos   = {1'b0, hcnt};
    vpos   = {1'b0, vcnt};
    h_last = (hpos == H_LAST_B);
    v_last = (vpos == V_LAST_B);
    active = (hpos < H_ACT_B) && (vpos < V_ACT_B);
    hs_raw = (hpos >= HS_BEG_B) && (hpos < HS_END_B);
    vs_raw = (vpos >= VS_BEG_B) && (vpos < VS_END_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? 12'd0 : vcnt + 12'd1;
    end else begin
      hcnt <= hcnt + 12'd1;
    end
  end

  // Element 0 is the request stage itself; element RESP_LATENCY lines up with the response.
  logic [RESP_LATENCY:0] de_pipe;
  logic [RESP_LATENCY:0] hs_pipe;
  logic [RESP_LATENCY:0] vs_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_pipe <= '0;
      hs_pipe <= '0;
      vs_pipe <= '0;
      req_sol <= 1'b0;
      req_sof <= 1'b0;
    end else begin
      de_pipe <= {de_pipe[RESP_LATENCY-1:0], active};
      hs_pipe <= {hs_pipe[RESP_LATENCY-1:0], hs_raw};
      vs_pipe <= {vs_pipe[RESP_LATENCY-1:0], vs_raw};
      req_sol <= active && (hcnt == 12'd0);
      req_sof <= active && (hcnt == 12'd0) && (vcnt == 12'd0);
    end
  end

  assign req_en = de_pipe[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_de    <= 1'b0;
      vid_hsync <= ~H_POL;
      vid_vsync <= ~V_POL;
      vid_red   <= '0;
      vid_green <= '0;
      vid_blue  <= '0;
    end else begin
      vid_de    <= de_pipe[RESP_LATENCY];
      vid_hsync <= hs_pipe[RESP_LATENCY] ? H_POL : ~H_POL;
      vid_vsync <= vs_pipe[RESP_LATENCY] ? V_POL : ~V_POL;
`ifdef VIDEO_TIMING_BLANK_ZERO_EN
      vid_red   <= de_pipe[RESP_LATENCY] ? resp_red   : 8'h00;
      vid_green <= de_pipe[RESP_LATENCY] ? resp_green : 8'h00;
      vid_blue  <= de_pipe[RESP_LATENCY] ? resp_blue  : 8'h00;
`else
      vid_red   <= resp_red;
      vid_green <= resp_green;
      vid_blue  <= resp_blue;
`endif
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: three pixel-index sources (latency 1/2/3) and one constant 0xAA source on a tiny 8x6 raster.
module tb_video_timing_gen;

  logic clk;
  logic rst;

  logic       o_en  [4];
  logic       o_sof [4];
  logic       o_sol [4];
  logic       o_de  [4];
  logic       o_hs  [4];
  logic       o_vs  [4];
  logic [7:0] o_r   [4];
  logic [7:0] o_g   [4];
  logic [7:0] o_b   [4];
  logic [7:0] rsp_r [4];
  logic [7:0] rsp_g [4];
  logic [7:0] rsp_b [4];

  typedef struct packed {
    logic [1:0]         inst;
    logic signed [15:0] k;
    logic               en;
    logic               sol;
    logic               sof;
    logic               de;
    logic               hs;
    logic               vs;
    logic [23:0]        rgb;
    logic               rgb_chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b0), .V_POL(1'b0), .RESP_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_en(o_en[0]), .req_sof(o_sof[0]), .req_sol(o_sol[0]),
    .resp_red(rsp_r[0]), .resp_green(rsp_g[0]), .resp_blue(rsp_b[0]),
    .vid_de(o_de[0]), .vid_hsync(o_hs[0]), .vid_vsync(o_vs[0]),
    .vid_red(o_r[0]), .vid_green(o_g[0]), .vid_blue(o_b[0]));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b0), .V_POL(1'b0), .RESP_LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .req_en(o_en[1]), .req_sof(o_sof[1]), .req_sol(o_sol[1]),
    .resp_red(rsp_r[1]), .resp_green(rsp_g[1]), .resp_blue(rsp_b[1]),
    .vid_de(o_de[1]), .vid_hsync(o_hs[1]), .vid_vsync(o_vs[1]),
    .vid_red(o_r[1]), .vid_green(o_g[1]), .vid_blue(o_b[1]));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b0), .V_POL(1'b0), .RESP_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst), .req_en(o_en[2]), .req_sof(o_sof[2]), .req_sol(o_sol[2]),
    .resp_red(rsp_r[2]), .resp_green(rsp_g[2]), .resp_blue(rsp_b[2]),
    .vid_de(o_de[2]), .vid_hsync(o_hs[2]), .vid_vsync(o_vs[2]),
    .vid_red(o_r[2]), .vid_green(o_g[2]), .vid_blue(o_b[2]));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b0), .V_POL(1'b0), .RESP_LATENCY(1)) dut_aa (
    .clk(clk), .rst(rst), .req_en(o_en[3]), .req_sof(o_sof[3]), .req_sol(o_sol[3]),
    .resp_red(rsp_r[3]), .resp_green(rsp_g[3]), .resp_blue(rsp_b[3]),
    .vid_de(o_de[3]), .vid_hsync(o_hs[3]), .vid_vsync(o_vs[3]),
    .vid_red(o_r[3]), .vid_green(o_g[3]), .vid_blue(o_b[3]));

  // Hand-derived expectation for cycle k after reset release (k < 0 means a reset cycle).
  // Raster is 8 wide x 6 tall: active h 0..3 / v 0..2, hsync at h 5, vsync on line 4, both active-low.
  function automatic exp_t calc(input int inst, input int k);
    exp_t e;
    int lat;
    int p;
    int h;
    int v;
    int idx;
    logic [7:0] b;
    e = '0;
    e.inst = 2'(inst);
    e.k = 16'(k);
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.rgb_chk = 1'b1;
    lat = (inst == 3) ? 1 : inst + 1;
    if (k >= 0) begin
      h = k % 8;
      v = (k / 8) % 6;
      e.en  = (h < 4) && (v < 3);
      e.sol = e.en && (h == 0);
      e.sof = e.sol && (v == 0);
      if (k >= lat + 1) begin
        p = k - lat - 1;
        h = p % 8;
        v = (p / 8) % 6;
        e.de = (h < 4) && (v < 3);
        e.hs = (h != 5);
        e.vs = (v != 4);
        if (inst == 3) begin
`ifdef VIDEO_TIMING_BLANK_ZERO_EN
          e.rgb = e.de ? 24'hAAAAAA : 24'h000000;
`else
          e.rgb = 24'hAAAAAA;
`endif
        end else if (e.de) begin
          idx = (p / 48) * 12 + v * 4 + h;
          b = 8'(idx);
          e.rgb = {b, ~b, b ^ 8'h5A};
        end
      end else if (inst == 3) begin
`ifdef VIDEO_TIMING_BLANK_ZERO_EN
        e.rgb = 24'h000000;
`else
        e.rgb_chk = 1'b0;
`endif
      end
    end
    return e;
  endfunction

  // Pixel source: answers each observed request RESP_LATENCY cycles later with its running index.
  logic [23:0] hist [3][4];
  logic [7:0]  cnt  [3];
  logic        rs;
  initial begin
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 8'd0;
      for (int j = 0; j < 4; j++) hist[i][j] = 24'h0;
      rsp_r[i] = 8'h00; rsp_g[i] = 8'h00; rsp_b[i] = 8'h00;
    end
    rsp_r[3] = 8'hAA; rsp_g[3] = 8'hAA; rsp_b[3] = 8'hAA;
    forever begin
      @(posedge clk);
      rs = rst;
      #1;
      for (int i = 0; i < 3; i++) begin
        if (rs) begin
          cnt[i] = 8'd0;
          for (int j = 0; j < 4; j++) hist[i][j] = 24'h0;
        end
        {rsp_r[i], rsp_g[i], rsp_b[i]} = hist[i][i];
      end
      @(negedge clk);
      if (!rs) begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
          hist[i][0] = o_en[i] ? {cnt[i], ~cnt[i], cnt[i] ^ 8'h5A} : 24'h0;
          if (o_en[i]) cnt[i] = cnt[i] + 8'd1;
        end
      end
    end
  end

  // Monitor: every cycle each instance presents a full output word; pop and compare.
  initial begin
    exp_t e;
    int   i;
    logic ok;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        i = int'(e.inst);
        ok = (o_en[i] == e.en) && (o_sol[i] == e.sol) && (o_sof[i] == e.sof) &&
             (o_de[i] == e.de) && (o_hs[i] == e.hs) && (o_vs[i] == e.vs) &&
             (!e.rgb_chk || ({o_r[i], o_g[i], o_b[i]} == e.rgb));
        n_tests++;
        if (!ok) begin
          n_fail++;
          $display("FAIL vid_chk inst%0d k=%0d: got en/sol/sof=%b%b%b de/hs/vs=%b%b%b rgb=%h, want %b%b%b %b%b%b rgb=%h (rgb checked=%b)",
                   i, e.k, o_en[i], o_sol[i], o_sof[i], o_de[i], o_hs[i], o_vs[i], {o_r[i], o_g[i], o_b[i]},
                   e.en, e.sol, e.sof, e.de, e.hs, e.vs, e.rgb, e.rgb_chk);
        end
      end
    end
  end

  // Stimulus: 5 reset cycles, two frames plus, a one-cycle reset at (v=1,h=2) of the third frame, then restart.
  initial begin
    int   k;
    logic smp;
    logic pulsed;
    rst = 1'b1;
    n_tests = 0;
    n_fail = 0;
    k = -1;
    pulsed = 1'b0;
    for (int cyc = 0; cyc < 190; cyc++) begin
      @(posedge clk);
      smp = rst;
      #1;
      if (smp) k = -1;
      else k = k + 1;
      for (int i = 0; i < 4; i++) exp_q.push_back(calc(i, k));
      if (cyc < 4) rst = 1'b1;
      else if (!pulsed && k == 106) begin
        rst = 1'b1;
        pulsed = 1'b1;
      end else rst = 1'b0;
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
